cp0_regfile: RTL and testbench

- System-coprocessor (CP0) register file that answers the writeback stage's CP0 access and exception/eret signalling.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Serves MFC0 reads and MTC0 writes, and records exception state.
- Runs the Count/Compare timer and produces the pending-interrupt and EPC outputs that the fetch/flush logic consumes.

---
 rtl/cp0_regfile_pkg.sv | 37 +++
 rtl/cp0_regfile_timer.sv | 64 ++++++
 rtl/cp0_regfile.sv | 143 ++++++++++++++
 tb/tb_cp0_regfile.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and bit positions
// of the Status/Cause fields.
package cp0_regfile_pkg;

  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_OV   = 5'h0C
  } exc_code_e;

  localparam int unsigned ST_IE      = 0;
  localparam int unsigned ST_EXL     = 1;
  localparam int unsigned ST_IM_LO   = 8;
  localparam int unsigned ST_BEV     = 22;
  localparam int unsigned CA_EXC_LO  = 2;
  localparam int unsigned CA_IP_LO   = 8;
  localparam int unsigned CA_IPHW_LO = 10;
  localparam int unsigned CA_TI      = 30;
  localparam int unsigned CA_BD      = 31;

  // Only address-error exceptions carry a meaningful faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: divided tick, free-running Count, Compare register and
// the sticky timer-interrupt flag TI.
module cp0_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wen_i,
  input  logic        compare_wen_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic        tick_q;
  logic        tick;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match, match_q;
  logic        ti_q, ti_d;

  assign tick  = (COUNT_DIV == 1) ? 1'b1 : tick_q;
  assign match = (count_q == compare_q);

  // TI fires on the first cycle of a match; match_q resets high so the
  // Count==Compare==0 state straight out of reset does not raise TI.
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_wen_i)
      count_d = wdata_i;
    else if (tick)
      count_d = count_q + 32'd1;
    if (compare_wen_i)
      compare_d = wdata_i;
    if (compare_wen_i)
      ti_d = 1'b0;
    else if (match && !match_q)
      ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b1;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= ~tick_q;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: MFC0/MTC0 access, exception/ERET state capture and the
// pending-interrupt computation consumed by fetch/flush.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  cp0_addr,
  input  logic        cp0_wen,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  input  logic [5:0]  ext_int_in,
  output logic [31:0] epc_out,
  output logic        int_pending,
  output logic        status_exl
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_ext_q;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic [31:0] count, compare;
  logic        ti;
  logic [31:0] status_rd, cause_rd;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk           (clk),
    .reset         (reset),
    .count_wen_i   (cp0_wen && (cp0_addr == CP0_COUNT)),
    .compare_wen_i (cp0_wen && (cp0_addr == CP0_COMPARE)),
    .wdata_i       (cp0_wdata),
    .count_o       (count),
    .compare_o     (compare),
    .ti_o          (ti)
  );

  // MTC0 first, then eret, then exception, so later assignments win on
  // shared fields while untouched MTC0 fields still land.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (cp0_wen) begin
      case (cp0_addr)
        CP0_STATUS: begin
          im_d  = cp0_wdata[ST_IM_LO +: 8];
          exl_d = cp0_wdata[ST_EXL];
          ie_d  = cp0_wdata[ST_IE];
        end
        CP0_CAUSE: ip_sw_d = cp0_wdata[CA_IP_LO +: 2];
        CP0_EPC:   epc_d   = cp0_wdata;
        default: ;
      endcase
    end
    if (eret)
      exl_d = 1'b0;
    if (exc_valid) begin
      exl_d     = 1'b1;
      exccode_d = exc_code;
      if (!exl_q) begin
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_bd;
      end
      if (is_addr_exc(exc_code))
        badvaddr_d = exc_badvaddr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= STATUS_RESET[ST_IM_LO +: 8];
      exl_q      <= STATUS_RESET[ST_EXL];
      ie_q       <= STATUS_RESET[ST_IE];
      ip_sw_q    <= '0;
      ip_ext_q   <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_sw_q    <= ip_sw_d;
      ip_ext_q   <= ext_int_in;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    status_rd                  = '0;
    status_rd[ST_BEV]          = 1'b1;
    status_rd[ST_IM_LO +: 8]   = im_q;
    status_rd[ST_EXL]          = exl_q;
    status_rd[ST_IE]           = ie_q;
    cause_rd                   = '0;
    cause_rd[CA_BD]            = bd_q;
    cause_rd[CA_TI]            = ti;
    cause_rd[CA_IPHW_LO +: 6]  = {ip_ext_q[5] | ti, ip_ext_q[4:0]};
    cause_rd[CA_IP_LO +: 2]    = ip_sw_q;
    cause_rd[CA_EXC_LO +: 5]   = exccode_q;
  end

  always_comb begin
    case (cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_rd;
      CP0_CAUSE:    cp0_rdata = cause_rd;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

  assign int_pending = ie_q & ~exl_q & (|(cause_rd[CA_IP_LO +: 8] & im_q));
  assign epc_out     = epc_q;
  assign status_exl  = exl_q;

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (COUNT_DIV=2).
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cp0_addr;
  logic        cp0_wen;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  ext_int_in;
  logic [31:0] epc_out;
  logic        int_pending;
  logic        status_exl;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  cp0_regfile #(.COUNT_DIV(2), .STATUS_RESET(32'h0040_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .cp0_addr     (cp0_addr),
    .cp0_wen      (cp0_wen),
    .cp0_wdata    (cp0_wdata),
    .cp0_rdata    (cp0_rdata),
    .exc_valid    (exc_valid),
    .exc_code     (exc_code),
    .exc_pc       (exc_pc),
    .exc_bd       (exc_bd),
    .exc_badvaddr (exc_badvaddr),
    .eret         (eret),
    .ext_int_in   (ext_int_in),
    .epc_out      (epc_out),
    .int_pending  (int_pending),
    .status_exl   (status_exl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    cp0_addr = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    cp0_addr  = a;
    cp0_wdata = d;
    cp0_wen   = 1'b1;
    @(negedge clk);
    cp0_wen   = 1'b0;
  endtask

  task automatic raise_exc(input logic [4:0] code, input logic [31:0] pc,
                           input logic bd, input logic [31:0] bva);
    exc_valid    = 1'b1;
    exc_code     = code;
    exc_pc       = pc;
    exc_bd       = bd;
    exc_badvaddr = bva;
    @(negedge clk);
    exc_valid    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c, cause;
    int first;

    reset = 1'b1; cp0_addr = '0; cp0_wen = 1'b0; cp0_wdata = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0;
    exc_badvaddr = '0; eret = 1'b0; ext_int_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rd_check("rst_count",    CP0_COUNT,    32'h0);
    rd_check("rst_badvaddr", CP0_BADVADDR, 32'h0);
    rd_check("rst_compare",  CP0_COMPARE,  32'h0);
    rd_check("rst_status",   CP0_STATUS,   32'h0040_0000);
    rd_check("rst_cause",    CP0_CAUSE,    32'h0);
    rd_check("rst_epc",      CP0_EPC,      32'h0);
    rd_check("rst_unmapped", 8'h08,        32'h0);
    check("rst_int_pending", {31'b0, int_pending}, 32'h0);
    check("rst_exl",         {31'b0, status_exl},  32'h0);
    check("rst_epc_out",     epc_out,              32'h0);
    @(negedge clk);

    // Status/Cause writable masks and software interrupts
    mtc0(CP0_STATUS, 32'hFFFF_FFFF);
    rd_check("status_mask", CP0_STATUS, 32'h0040_FF03);
    check("status_exl_set", {31'b0, status_exl}, 32'h1);
    mtc0(CP0_STATUS, 32'h0000_FF01);
    rd_check("status_ie_im", CP0_STATUS, 32'h0040_FF01);
    check("no_pending_yet", {31'b0, int_pending}, 32'h0);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    rd_check("cause_mask", CP0_CAUSE, 32'h0000_0300);
    check("sw_int_pending", {31'b0, int_pending}, 32'h1);
    mtc0(CP0_CAUSE, 32'h0);
    check("sw_int_cleared", {31'b0, int_pending}, 32'h0);
    mtc0(8'h08, 32'hFFFF_FFFF);
    rd_check("unmapped_write", 8'h08, 32'h0);

    // Exceptions, EXL nesting and eret
    raise_exc(EXC_ADEL, 32'hBFC0_0104, 1'b1, 32'h0000_0003);
    check("exc1_epc_out", epc_out, 32'hBFC0_0100);
    rd_check("exc1_epc",      CP0_EPC,      32'hBFC0_0100);
    rd_check("exc1_cause",    CP0_CAUSE,    32'h8000_0010);
    rd_check("exc1_badvaddr", CP0_BADVADDR, 32'h0000_0003);
    check("exc1_exl", {31'b0, status_exl}, 32'h1);
    raise_exc(EXC_OV, 32'h0000_1000, 1'b0, 32'hDEAD_BEEF);
    rd_check("exc2_epc_kept", CP0_EPC,      32'hBFC0_0100);
    rd_check("exc2_cause",    CP0_CAUSE,    32'h8000_0030);
    rd_check("exc2_bva_kept", CP0_BADVADDR, 32'h0000_0003);
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    check("eret_exl",   {31'b0, status_exl}, 32'h0);
    check("eret_epc",   epc_out,             32'hBFC0_0100);

    // Exception beats a same-cycle MTC0 EPC
    cp0_addr = CP0_EPC; cp0_wdata = 32'h0000_AAAA; cp0_wen = 1'b1;
    raise_exc(EXC_ADES, 32'h0000_0400, 1'b0, 32'h1234_5677);
    cp0_wen = 1'b0;
    rd_check("exc3_epc",      CP0_EPC,      32'h0000_0400);
    rd_check("exc3_badvaddr", CP0_BADVADDR, 32'h1234_5677);
    rd_check("exc3_cause",    CP0_CAUSE,    32'h0000_0014);
    mtc0(CP0_BADVADDR, 32'hFFFF_FFFF);
    rd_check("badvaddr_ro", CP0_BADVADDR, 32'h1234_5677);
    eret = 1'b1; @(negedge clk); eret = 1'b0;

    ext_int_in = 6'b000100;
    @(negedge clk);
    rd_check("ext_int_ip12", CP0_CAUSE, 32'h0000_1014);
    ext_int_in = '0;
    @(negedge clk);

    // Timer: Count reaches Compare=10 after 20 cycles, TI one cycle later
    mtc0(CP0_STATUS, 32'h0000_8001);
    mtc0(CP0_COMPARE, 32'd10);
    mtc0(CP0_COUNT, 32'd0);
    first = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      rd(CP0_COUNT, c);
      rd(CP0_CAUSE, cause);
      if (i == 20) check("count_after_20", c, 32'd10);
      if (c == 32'd10 && first == 0) begin
        first = i;
        check("ti_at_match", {31'b0, cause[30]}, 32'h0);
      end else if (first != 0 && i == first + 1) begin
        check("ti_after_match", {31'b0, cause[30]}, 32'h1);
      end
    end
    rd(CP0_CAUSE, cause);
    check("timer_ip7", {31'b0, cause[15]}, 32'h1);
    check("timer_int_pending", {31'b0, int_pending}, 32'h1);
    mtc0(CP0_COMPARE, 32'd1000);
    check("compare_clr_pending", {31'b0, int_pending}, 32'h0);
    rd(CP0_CAUSE, cause);
    check("compare_clr_ti", {30'b0, cause[30], cause[15]}, 32'h0);

    // Count writes in consecutive cycles cover both tick phases
    mtc0(CP0_COUNT, 32'h100);
    rd_check("count_wr_a", CP0_COUNT, 32'h100);
    mtc0(CP0_COUNT, 32'h200);
    rd_check("count_wr_b", CP0_COUNT, 32'h200);

    // exc_valid > eret > MTC0 on EXL; MTC0 IE/IM still land
    exc_valid = 1'b1; exc_code = EXC_SYS; exc_pc = 32'h0000_2000; exc_bd = 1'b0;
    eret = 1'b1; cp0_addr = CP0_STATUS; cp0_wdata = 32'h0; cp0_wen = 1'b1;
    @(negedge clk);
    exc_valid = 1'b0; eret = 1'b0; cp0_wen = 1'b0;
    rd_check("prio_status", CP0_STATUS, 32'h0040_0002);
    check("prio_epc", epc_out, 32'h0000_2000);
    eret = 1'b1; cp0_addr = CP0_STATUS; cp0_wdata = 32'h3; cp0_wen = 1'b1;
    @(negedge clk);
    eret = 1'b0; cp0_wen = 1'b0;
    rd_check("eret_over_mtc0", CP0_STATUS, 32'h0040_0001);

    // Count wrap with no spurious TI
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    rd(CP0_COUNT, c);
    check("wrap_hold", c, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rd(CP0_COUNT, c);
      if (c != 32'hFFFF_FFFF) break;
    end
    check("wrap_zero", c, 32'h0);
    repeat (4) @(negedge clk);
    rd(CP0_CAUSE, cause);
    check("wrap_no_ti", {31'b0, cause[30]}, 32'h0);

    // Reset dominates all inputs
    reset = 1'b1; cp0_addr = CP0_STATUS; cp0_wdata = 32'hFFFF_FFFF; cp0_wen = 1'b1;
    exc_valid = 1'b1; exc_code = EXC_ADEL; exc_pc = 32'h0000_3000; exc_badvaddr = 32'h55;
    @(negedge clk);
    reset = 1'b0; cp0_wen = 1'b0; exc_valid = 1'b0;
    rd_check("rst2_count",    CP0_COUNT,    32'h0);
    rd_check("rst2_status",   CP0_STATUS,   32'h0040_0000);
    rd_check("rst2_badvaddr", CP0_BADVADDR, 32'h0);
    check("rst2_epc", epc_out, 32'h0);
    check("rst2_exl", {31'b0, status_exl}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
